// File: rtl/uart_wb_tx_sched.sv
// Schedules bytes from two requesters onto a Wishbone-attached UART: init, poll TX-full, write DATA.
// Optional bus timeout watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_wb_tx_sched #(
    parameter logic [15:0] PRESCALE  = 16'd2,
    parameter logic [31:0] CTRL_INIT = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    input  logic        ack_i,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        init_done,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] ADR_DATA = 32'h0000_0000;
    localparam logic [31:0] ADR_PS   = 32'h0000_0004;
    localparam logic [31:0] ADR_CTRL = 32'h0000_0100;
    localparam logic [31:0] ADR_RIS  = 32'h0000_0200;

    typedef enum logic [2:0] {INIT_PS, INIT_CTRL, IDLE, POLL, WRITE} state_t;

    state_t      state, state_nx;
    logic        cyc_q;
    logic [31:0] adr_q, dat_q;
    logic        we_q;
    logic        grant, grant_nx, prio;
    logic [7:0]  byte_q;
    logic        init_q;
    logic        tmo;
    logic        done;
    logic        launch;
    logic [31:0] bus_adr, bus_dat;
    logic        bus_we;
    logic        wr_ack;

    // ack_i only counts while a cycle is open, so stray acks are ignored.
    assign done   = cyc_q && (ack_i || tmo);
    assign launch = (state != IDLE) && !cyc_q;
    assign wr_ack = (state == WRITE) && cyc_q && ack_i;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        bus_adr  = ADR_DATA;
        bus_dat  = 32'h0;
        bus_we   = 1'b0;
        case (state)
            INIT_PS: begin
                bus_adr = ADR_PS;
                bus_dat = {16'h0, PRESCALE};
                bus_we  = 1'b1;
                if (done) state_nx = INIT_CTRL;
            end
            INIT_CTRL: begin
                bus_adr = ADR_CTRL;
                bus_dat = CTRL_INIT;
                bus_we  = 1'b1;
                if (done) state_nx = IDLE;
            end
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nx = POLL;
                    if (prio == 1'b0) grant_nx = req0_valid ? 1'b0 : 1'b1;
                    else              grant_nx = req1_valid ? 1'b1 : 1'b0;
                end
            end
            POLL: begin
                bus_adr = ADR_RIS;
                // A timed-out or TX-full poll simply stays here and relaunches.
                if (done && ack_i && !dat_i[0]) state_nx = WRITE;
            end
            WRITE: begin
                bus_adr = ADR_DATA;
                bus_dat = {24'h0, byte_q};
                bus_we  = 1'b1;
                if (done) state_nx = IDLE;
            end
            default: state_nx = INIT_PS;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= INIT_PS;
            cyc_q  <= 1'b0;
            adr_q  <= 32'h0;
            dat_q  <= 32'h0;
            we_q   <= 1'b0;
            grant  <= 1'b0;
            prio   <= 1'b0;
            byte_q <= 8'h0;
            init_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (launch) begin
                cyc_q <= 1'b1;
                adr_q <= bus_adr;
                dat_q <= bus_dat;
                we_q  <= bus_we;
            end else if (done) begin
                cyc_q <= 1'b0;
            end
            if (state == IDLE && state_nx == POLL) begin
                grant  <= grant_nx;
                prio   <= ~grant_nx;
                byte_q <= grant_nx ? req1_data : req0_data;
            end
            if (state == INIT_CTRL && done) init_q <= 1'b1;
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Fires on the 255th consecutive unacknowledged cycle.
    assign tmo = cyc_q && !ack_i && (tmo_cnt == 8'd254);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= 8'h0;
            err_q   <= 1'b0;
        end else begin
            if (!cyc_q || ack_i || tmo) tmo_cnt <= 8'h0;
            else                        tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign we_o       = we_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign sel_o      = 4'hF;
    assign req0_ready = wr_ack && !grant;
    assign req1_ready = wr_ack && grant;
    assign init_done  = init_q;
    assign busy       = (state == POLL) || (state == WRITE);

endmodule

// File: tb/tb_uart_wb_tx_sched.sv
// Directed bench for uart_wb_tx_sched with a Wishbone UART slave model (DATA writes form the RX loopback FIFO).
module tb_uart_wb_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr_o, dat_o;
    logic [31:0] dat_i_r = 32'h0;
    logic [3:0]  sel_o;
    logic        cyc_o, stb_o, we_o;
    logic        ack_r = 1'b0, stray = 1'b0;
    logic        ack_i;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_data = 8'h0, req1_data = 8'h0;
    logic        req0_ready, req1_ready, init_done, busy, err;

    int n_cmp = 0, n_err = 0;
    int r0_pulses = 0, r1_pulses = 0, ready_bad = 0, bus_bad = 0;
    bit ack_en = 1'b1;

    typedef struct {logic [31:0] adr; logic [31:0] dat; logic we;} txn_t;
    txn_t        log_q[$];
    logic [31:0] ris_q[$];

    always #5 clk = ~clk;
    assign ack_i = ack_r | stray;

    uart_wb_tx_sched #(.PRESCALE(16'd2), .CTRL_INIT(32'h1)) dut (
        .clk_i(clk), .rst_i(rst), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i_r),
        .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .init_done(init_done), .busy(busy), .err(err)
    );

    // Slave: acks one cycle after the strobe is seen, logs each completed cycle.
    always @(posedge clk) begin
        if (cyc_o && stb_o && !ack_r && ack_en) begin
            log_q.push_back('{adr_o, dat_o, we_o});
            if (!we_o) begin
                if (ris_q.size() > 0) dat_i_r <= ris_q.pop_front();
                else                  dat_i_r <= 32'h0;
            end
            ack_r <= 1'b1;
        end else begin
            ack_r <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (req0_ready) r0_pulses++;
        if (req1_ready) r1_pulses++;
        if ((req0_ready || req1_ready) && !(ack_i && cyc_o && we_o && adr_o == 32'h0)) ready_bad++;
        if (req0_ready && req1_ready) ready_bad++;
        if (cyc_o && sel_o !== 4'hF) bus_bad++;
        if (cyc_o !== stb_o) bus_bad++;
    end

    function automatic int count_writes();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].we && log_q[i].adr == 32'h0) n++;
        return n;
    endfunction

    task automatic wait_init(input string name);
        for (int i = 0; i < 50 && !init_done; i++) @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b1) begin n_err++; $display("FAIL %s_init_done: got %b expected 1", name, init_done); end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_init("do_reset");
        repeat (2) @(negedge clk);
    endtask

    task automatic send0(input logic [7:0] b, input string name);
        bit seen = 0;
        @(posedge clk); #1 req0_data = b; req0_valid = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL %s_ready_timeout: got no ready expected pulse", name); end
        @(posedge clk); #1 req0_valid = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        @(negedge clk);
        n_cmp++;
        if ({cyc_o, stb_o, we_o, req0_ready, req1_ready, init_done, busy, err} !== 8'h0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000000",
                {cyc_o, stb_o, we_o, req0_ready, req1_ready, init_done, busy, err});
        end
        n_cmp++;
        if (adr_o !== 32'h0 || dat_o !== 32'h0) begin
            n_err++; $display("FAIL reset_bus: got adr %h dat %h expected 0 0", adr_o, dat_o);
        end
        base = log_q.size();
        @(posedge clk); #1 rst = 1'b0;
        wait_init("reset");
        n_cmp++;
        if (log_q.size() - base !== 2) begin n_err++; $display("FAIL init_count: got %0d expected 2", log_q.size() - base); end
        else begin
            n_cmp++;
            if (log_q[base].adr !== 32'h4 || log_q[base].dat !== 32'h2 || log_q[base].we !== 1'b1) begin
                n_err++; $display("FAIL init_ps: got adr %h dat %h we %b expected 4 2 1", log_q[base].adr, log_q[base].dat, log_q[base].we);
            end
            n_cmp++;
            if (log_q[base+1].adr !== 32'h100 || log_q[base+1].dat !== 32'h1 || log_q[base+1].we !== 1'b1) begin
                n_err++; $display("FAIL init_ctrl: got adr %h dat %h we %b expected 100 1 1", log_q[base+1].adr, log_q[base+1].dat, log_q[base+1].we);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int base = log_q.size();
        int p0 = r0_pulses, p1 = r1_pulses;
        send0(8'h11, "single");
        n_cmp++;
        if (log_q.size() - base !== 2) begin n_err++; $display("FAIL single_count: got %0d expected 2", log_q.size() - base); end
        else begin
            n_cmp++;
            if (log_q[base].adr !== 32'h200 || log_q[base].we !== 1'b0) begin
                n_err++; $display("FAIL single_poll: got adr %h we %b expected 200 0", log_q[base].adr, log_q[base].we);
            end
            n_cmp++;
            if (log_q[base+1].adr !== 32'h0 || log_q[base+1].dat !== 32'h11 || log_q[base+1].we !== 1'b1) begin
                n_err++; $display("FAIL single_write: got adr %h dat %h expected 0 11", log_q[base+1].adr, log_q[base+1].dat);
            end
        end
        n_cmp++;
        if (r0_pulses - p0 !== 1 || r1_pulses - p1 !== 0) begin
            n_err++; $display("FAIL single_ready: got r0 %0d r1 %0d expected 1 0", r0_pulses - p0, r1_pulses - p1);
        end
    endtask

    task automatic test_poll_retry();
        int base = log_q.size();
        int busy_low = 0, reads = 0;
        bit seen = 0;
        ris_q = '{32'h1, 32'h1, 32'h1, 32'h0};
        @(posedge clk); #1 req0_data = 8'h5A; req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_low++;
            seen = req0_ready;
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int i = base; i < log_q.size(); i++) if (!log_q[i].we && log_q[i].adr == 32'h200) reads++;
        n_cmp++;
        if (reads !== 4) begin n_err++; $display("FAIL poll_reads: got %0d expected 4", reads); end
        n_cmp++;
        if (log_q.size() - base !== 5 || log_q[log_q.size()-1].dat !== 32'h5A) begin
            n_err++; $display("FAIL poll_write: got %0d txns expected 5 ending in 5a", log_q.size() - base);
        end
        n_cmp++;
        if (busy_low !== 0) begin n_err++; $display("FAIL poll_busy: got %0d low cycles expected 0", busy_low); end
    endtask

    task automatic test_valid_drop();
        int base = log_q.size();
        int p1 = r1_pulses;
        bit seen = 0;
        @(posedge clk); #1 req1_data = 8'h77; req1_valid = 1'b1;
        @(posedge clk); #1 req1_data = 8'h00; req1_valid = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = req1_ready; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (r1_pulses - p1 !== 1) begin n_err++; $display("FAIL drop_ready: got %0d expected 1", r1_pulses - p1); end
        n_cmp++;
        if (log_q.size() - base !== 2 || log_q[log_q.size()-1].dat !== 32'h77) begin
            n_err++; $display("FAIL drop_data: got %0d txns expected 2 ending in 77", log_q.size() - base);
        end
    endtask

    task automatic test_stray_ack();
        int base = log_q.size();
        int p0 = r0_pulses, p1 = r1_pulses;
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({cyc_o, busy} !== 2'b00 || log_q.size() !== base || r0_pulses !== p0 || r1_pulses !== p1) begin
            n_err++; $display("FAIL stray_ack: got cyc %b busy %b txns %0d expected 0 0 0", cyc_o, busy, log_q.size() - base);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] rx[$];
        int base = log_q.size();
        for (int i = 1; i <= 8; i++) send0(8'(i * 8'h11), "loop");
        for (int i = base; i < log_q.size(); i++) if (log_q[i].we && log_q[i].adr == 32'h0) rx.push_back(log_q[i].dat[7:0]);
        n_cmp++;
        if (rx.size() !== 8) begin n_err++; $display("FAIL loop_count: got %0d expected 8", rx.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (rx[i] !== 8'((i + 1) * 8'h11)) begin
                    n_err++; $display("FAIL loop_byte%0d: got %h expected %h", i, rx[i], 8'((i + 1) * 8'h11));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [4] = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
        logic [7:0] got[$];
        int base;
        do_reset();
        base = log_q.size();
        @(posedge clk); #1 req0_data = 8'hA0; req1_data = 8'hB0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 400 && got.size() < 4; i++) begin
            @(negedge clk);
            got.delete();
            for (int k = base; k < log_q.size(); k++) if (log_q[k].we && log_q[k].adr == 32'h0) got.push_back(log_q[k].dat[7:0]);
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (got.size() < 4) begin n_err++; $display("FAIL rr_count: got %0d expected 4", got.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got[i] !== exp[i]) begin n_err++; $display("FAIL rr_order%0d: got %h expected %h", i, got[i], exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, p0, w0;
        ack_en = 1'b0;
        @(posedge clk); #1 req0_data = 8'h99; req0_valid = 1'b1;
        for (int i = 0; i < 20 && !(cyc_o && !we_o); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        p0 = r0_pulses; w0 = count_writes();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cyc_o, stb_o, busy, init_done, req0_ready} !== 5'b0) begin
            n_err++; $display("FAIL midreset_async: got %b expected 00000", {cyc_o, stb_o, busy, init_done, req0_ready});
        end
        req0_valid = 1'b0;
        base = log_q.size();
        ack_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_init("midreset");
        repeat (4) @(negedge clk);
        n_cmp++;
        if (log_q.size() - base !== 2 || log_q[base].adr !== 32'h4 || count_writes() !== w0 || r0_pulses !== p0) begin
            n_err++; $display("FAIL midreset_restart: got %0d txns writes+%0d pulses+%0d expected 2 0 0",
                log_q.size() - base, count_writes() - w0, r0_pulses - p0);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
`ifdef UART_SCHED_TIMEOUT_EN
        int exp_hi = 255;
        logic exp_err = 1'b1;
`else
        int exp_hi = 400;
        logic exp_err = 1'b0;
`endif
        ack_en = 1'b0;
        @(posedge clk); #1 req0_data = 8'h42; req0_valid = 1'b1;
        for (int i = 0; i < 20 && !cyc_o; i++) @(negedge clk);
        while (cyc_o && hi < 400) begin hi++; @(negedge clk); end
        n_cmp++;
        if (hi !== exp_hi) begin n_err++; $display("FAIL timeout_cycles: got %0d expected %0d", hi, exp_hi); end
        n_cmp++;
        if (err !== exp_err) begin n_err++; $display("FAIL timeout_err: got %b expected %b", err, exp_err); end
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL timeout_err_clear: got %b expected 0", err); end
        ack_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_poll_retry();
        test_valid_drop();
        test_stray_ack();
        test_loopback();
        test_round_robin();
        test_reset_mid();
        n_cmp++;
        if (ready_bad !== 0 || bus_bad !== 0) begin
            n_err++; $display("FAIL bus_monitor: got ready_bad %0d bus_bad %0d expected 0 0", ready_bad, bus_bad);
        end
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_wb_tx_sched.md
UART_WB_TX_SCHED -- requirements
Module: uart_wb_tx_sched

Interface
REQ-001 SHALL provide parameter PRESCALE, default 16'd2: value written to UART prescale register at init.
REQ-002 SHALL provide parameter CTRL_INIT, default 32'h1: value written to UART control register at init (enable).
REQ-003 SHALL provide ports as follows; one clock; reset is asynchronous and active-high:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- adr_o, output, 32: Wishbone address.
- dat_o, output, 32: Wishbone write data.
- dat_i, input, 32: Wishbone read data.
- sel_o, output, 4: byte selects.
- cyc_o, output, 1: Wishbone cycle.
- stb_o, output, 1: Wishbone strobe.
- we_o, output, 1: Wishbone write enable.
- ack_i, input, 1: Wishbone acknowledge.
- req0_valid, input, 1: requester 0 has a byte.
- req0_data, input, 8: requester 0 byte.
- req0_ready, output, 1: requester 0 byte accepted.
- req1_valid, input, 1: requester 1 has a byte.
- req1_data, input, 8: requester 1 byte.
- req1_ready, output, 1: requester 1 byte accepted.
- init_done, output, 1: UART configured.
- busy, output, 1: transfer in progress.
- err, output, 1: sticky bus timeout flag.

Function
REQ-004 SHALL implement FSM states INIT_PS, INIT_CTRL, IDLE, POLL, WRITE.
REQ-005 SHALL perform Wishbone classic single cycles:
- cyc_o and stb_o assert together in the cycle after state entry and hold until ack_i is sampled high.
- Both deassert in the following cycle.
- sel_o is 4'hF for every cycle.
REQ-006 SHALL, after reset, write PRESCALE to address 32'h0004 (INIT_PS), then CTRL_INIT to address 32'h0100 (INIT_CTRL), then enter IDLE with init_done=1.
REQ-007 SHALL, in IDLE with any reqN_valid high, grant one requester:
- Round-robin; requester 0 has priority after reset.
- After a grant to N, the other requester has priority.
- The granted data is latched.
REQ-008 SHALL, in POLL, read RIS at address 32'h0200 (we_o=0); on ack, enter WRITE if dat_i[0] (TX FIFO full) is 0, else repeat POLL.
REQ-009 SHALL, in WRITE, write {24'h0, latched byte} to address 32'h0000; on ack, return to IDLE.
REQ-010 SHALL pulse reqN_ready for exactly one cycle, coincident with the DATA-write ack, for the granted requester only.
REQ-011 SHALL require requesters to hold valid and data until ready; deasserting valid after grant does not cancel the write.
REQ-012 SHALL NOT change the grant while in POLL or WRITE; a simultaneous arrival of the other requester waits.
REQ-013 SHALL assert busy in POLL and WRITE, and deassert it in IDLE and the INIT states.
REQ-014 SHALL ignore ack_i while cyc_o is low.

Reset
REQ-015 SHALL, on rst_i high (asynchronous), immediately drive:
- cyc_o=0, stb_o=0, we_o=0.
- adr_o=0, dat_o=0.
- reqN_ready=0, init_done=0, busy=0, err=0.
- State INIT_PS, priority pointer to requester 0.
REQ-016 SHALL, on reset asserted mid-cycle, abandon the bus cycle without a ready pulse and restart initialization after release.

Configuration
REQ-017 SHALL, with macro UART_SCHED_TIMEOUT_EN defined:
- Count cycles with cyc_o high and no ack.
- When the count reaches 255, drop cyc_o/stb_o and set err=1 (sticky until reset).
- Proceed as if acked: INIT states advance; POLL retries; WRITE returns to IDLE without a ready pulse.
REQ-018 SHALL, without UART_SCHED_TIMEOUT_EN, wait indefinitely for ack_i and tie err to 0.

Verification
REQ-019 SHALL cover: reset release with PRESCALE=2 -> writes 0x0004=2 then 0x0100=1, then init_done=1.
REQ-020 SHALL cover: req0 sends 0x11 with RIS=0 -> one RIS read, DATA write 0x11, one req0_ready pulse on the ack.
REQ-021 SHALL cover: req0 and req1 both valid continuously with bytes 0xA0/0xB0 -> DATA writes alternate 0xA0, 0xB0, 0xA0, 0xB0.
REQ-022 SHALL cover: RIS returns 0x1 three times, then 0x0 -> four RIS reads, one DATA write, busy high throughout.
REQ-023 SHALL cover: UART loopback with bytes 0x11..0x88 via req0 -> UART RX FIFO holds 8 bytes in order.
REQ-024 SHALL cover: UART_SCHED_TIMEOUT_EN with ack_i held low -> cyc_o drops after 255 cycles and err=1; without the macro, cyc_o stays high.
